// File: rtl/buffer_if_id.sv
`default_nettype none
// ============================================================================
// Module      : buffer_if_id
// Description : Two-entry IF/ID pipeline buffer between instruction fetch and
//               decode. Holds {instruction, PC+4} pairs in a small circular
//               buffer with valid/ready handshakes on both sides and a
//               synchronous flush for taken branches and jumps.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_if_id #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_inst,
   input  logic [WIDTH-1:0] in_pc4,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_inst,
   output logic [WIDTH-1:0] out_pc4,
   output logic [1:0]       count
);

   // Occupancy encodings; the count register doubles as the buffer state.
   localparam logic [1:0] C_EMPTY = 2'd0;
   localparam logic [1:0] C_FULL  = 2'd2;

   logic [WIDTH-1:0] inst_q [2];
   logic [WIDTH-1:0] inst_d [2];
   logic [WIDTH-1:0] pc4_q  [2];
   logic [WIDTH-1:0] pc4_d  [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q,  count_d;

   logic             w_push;
   logic             w_pop;

   // Handshake outputs decode from state only, so there is no in->out bypass.
   always_comb begin
      in_ready  = !rst && (count_q != C_FULL);
      out_valid = (count_q != C_EMPTY);
      out_inst  = '0;
      out_pc4   = '0;
      if (count_q != C_EMPTY) begin
         out_inst = inst_q[rd_ptr_q];
         out_pc4  = pc4_q[rd_ptr_q];
      end
      count  = count_q;
      // A flush cancels both sides of the transfer in the same cycle.
      w_push = in_valid && in_ready && !flush;
      w_pop  = out_valid && out_ready && !flush;
   end

   // Next-state: flush realigns the pointers and empties the buffer,
   // otherwise push writes at the tail and pop advances the head.
   always_comb begin
      inst_d   = inst_q;
      pc4_d    = pc4_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         count_d  = C_EMPTY;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (w_push) begin
            inst_d[wr_ptr_q] = in_inst;
            pc4_d[wr_ptr_q]  = in_pc4;
            wr_ptr_d         = !wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_d = !rd_ptr_q;
         end
         if (w_push && !w_pop) begin
            count_d = count_q + 2'd1;
         end else if (w_pop && !w_push) begin
            count_d = count_q - 2'd1;
         end
      end
   end

   // State registers; reset also clears the stored entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q[0] <= '0;
         inst_q[1] <= '0;
         pc4_q[0]  <= '0;
         pc4_q[1]  <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= C_EMPTY;
      end else begin
         inst_q    <= inst_d;
         pc4_q     <= pc4_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_buffer_if_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_if_id
// Description : Self-checking bench for buffer_if_id: directed vector table,
//               pointer-wrap stream and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_if_id;

   localparam logic [31:0] C_A = 32'h20080005;
   localparam logic [31:0] C_B = 32'h21090003;
   localparam logic [31:0] C_C = 32'h01095020;
   localparam logic [31:0] C_D = 32'hAC0A0000;
   localparam logic [31:0] C_J = 32'h08000010;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_inst, in_pc4, out_inst, out_pc4;
   logic [1:0]  count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   buffer_if_id #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_inst  (in_inst),
      .in_pc4   (in_pc4),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_inst (out_inst),
      .out_pc4  (out_pc4),
      .count    (count)
   );

   typedef struct {
      logic        r, iv;
      logic [31:0] inst, pc;
      logic        fl, ordy;
      logic        e_ir, e_ov;
      logic [31:0] e_oi, e_op;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t tbl [25];

   // Reference model: an in-order queue of {inst, pc4}, depth 2.
   logic [31:0] mq_i [$];
   logic [31:0] mq_p [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic fl, input logic ordy);
      @(negedge clk);
      rst = r; in_valid = iv; in_inst = inst; in_pc4 = pc; flush = fl; out_ready = ordy;
      #1;
   endtask

   // One cycle against the model: compare current outputs, clock, update model.
   task automatic step(input logic r, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic fl, input logic ordy,
                       output logic accepted);
      logic        rdy, ov;
      drive(r, iv, inst, pc, fl, ordy);
      rdy = !r && (mq_i.size() < 2);
      ov  = (mq_i.size() > 0);
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, rdy});
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, ov});
      chk("m_out_inst", out_inst, ov ? mq_i[0] : 32'h0);
      chk("m_out_pc4", out_pc4, ov ? mq_p[0] : 32'h0);
      chk("m_count", {30'b0, count}, mq_i.size());
      accepted = iv && rdy && !fl;
      @(posedge clk);
      if (r || fl) begin
         mq_i.delete();
         mq_p.delete();
      end else begin
         if (ov && ordy) begin
            void'(mq_i.pop_front());
            void'(mq_p.pop_front());
         end
         if (accepted) begin
            mq_i.push_back(inst);
            mq_p.push_back(pc);
         end
      end
   endtask

   initial begin
      logic        acc;
      logic [31:0] stream [6];
      int          k;
      int          budget;

      //            rst  iv   inst  pc      fl   ordy  ir   ov   oi    op      cnt
      tbl[0]  = '{1'b1,1'b1,C_A, 32'h04,1'b0,1'b0, 1'b0,1'b0,32'h0,32'h0, 2'd0};
      tbl[1]  = '{1'b1,1'b1,C_A, 32'h04,1'b0,1'b0, 1'b0,1'b0,32'h0,32'h0, 2'd0};
      tbl[2]  = '{1'b0,1'b1,C_A, 32'h04,1'b0,1'b1, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[3]  = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 1'b1,1'b1,C_A, 32'h04, 2'd1};
      tbl[4]  = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[5]  = '{1'b0,1'b1,C_A, 32'h04,1'b0,1'b0, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[6]  = '{1'b0,1'b1,C_B, 32'h08,1'b0,1'b0, 1'b1,1'b1,C_A, 32'h04, 2'd1};
      tbl[7]  = '{1'b0,1'b1,C_C, 32'h0C,1'b0,1'b0, 1'b0,1'b1,C_A, 32'h04, 2'd2};
      tbl[8]  = '{1'b0,1'b1,C_C, 32'h0C,1'b0,1'b1, 1'b0,1'b1,C_A, 32'h04, 2'd2};
      tbl[9]  = '{1'b0,1'b1,C_C, 32'h0C,1'b0,1'b1, 1'b1,1'b1,C_B, 32'h08, 2'd1};
      tbl[10] = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 1'b1,1'b1,C_C, 32'h0C, 2'd1};
      tbl[11] = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[12] = '{1'b0,1'b1,C_A, 32'h04,1'b0,1'b0, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[13] = '{1'b0,1'b1,C_D, 32'h10,1'b0,1'b1, 1'b1,1'b1,C_A, 32'h04, 2'd1};
      tbl[14] = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b1,1'b1,C_D, 32'h10, 2'd1};
      tbl[15] = '{1'b0,1'b1,C_B, 32'h08,1'b0,1'b0, 1'b1,1'b1,C_D, 32'h10, 2'd1};
      tbl[16] = '{1'b0,1'b1,C_J, 32'h14,1'b1,1'b1, 1'b0,1'b1,C_D, 32'h10, 2'd2};
      tbl[17] = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[18] = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[19] = '{1'b0,1'b1,C_C, 32'h0C,1'b0,1'b0, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[20] = '{1'b1,1'b1,C_A, 32'h04,1'b0,1'b1, 1'b0,1'b1,C_C, 32'h0C, 2'd1};
      tbl[21] = '{1'b0,1'b1,C_A, 32'h04,1'b0,1'b0, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[22] = '{1'b0,1'b1,C_B, 32'h08,1'b1,1'b0, 1'b1,1'b1,C_A, 32'h04, 2'd1};
      tbl[23] = '{1'b0,1'b1,C_B, 32'h08,1'b0,1'b1, 1'b1,1'b0,32'h0,32'h0, 2'd0};
      tbl[24] = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 1'b1,1'b1,C_B, 32'h08, 2'd1};

      // Establish a known state before the table starts checking.
      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc4 = '0; flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].r, tbl[i].iv, tbl[i].inst, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
         chk($sformatf("v%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, tbl[i].e_ir});
         chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
         chk($sformatf("v%0d_out_inst", i),  out_inst, tbl[i].e_oi);
         chk($sformatf("v%0d_out_pc4", i),   out_pc4,  tbl[i].e_op);
         chk($sformatf("v%0d_count", i),     {30'b0, count}, {30'b0, tbl[i].e_cnt});
         @(posedge clk);
      end

      // Model-tracked section starts from a reset.
      mq_i.delete(); mq_p.delete();
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

      // Pointer wrap: six instructions streamed with out_ready toggling.
      stream = '{C_A, C_B, C_C, C_D, C_J, 32'h00851820};
      k = 0;
      budget = 0;
      while ((k < 6 || mq_i.size() != 0) && budget < 40) begin
         step(1'b0, k < 6, (k < 6) ? stream[k] : 32'h0, 32'h100 + 32'(k * 4),
              1'b0, budget[0] == 1'b0, acc);
         if (acc) k++;
         budget++;
      end
      chk("wrap_all_accepted", 32'(k), 32'd6);
      chk("wrap_drained_in_budget", {31'b0, budget < 40}, 32'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 500; n++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, $urandom, $urandom,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, acc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
